muldiv_core: RTL and testbench

- Iterative unsigned multiply/divide responder for the ALU's MUL/DIV multi-cycle path.
- The ALU (initiator) drives valid/mode/in_A/in_B.
- This block accepts one operation, computes it one bit per cycle, then returns a registered 64-bit result with a single-cycle ready pulse.
- It replaces the behavioural muldiv model with a synthesizable, fixed-latency FSM.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step_cnt.sv | 27 ++
 rtl/muldiv_core.sv | 131 +++++++++++++
 tb/tb_muldiv_core.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide path.
// The ALU uses the same mode encodings.
package muldiv_pkg;

  localparam int unsigned DefaultDataW = 32;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step_cnt.sv
// Iteration counter shared by the multiply and divide sequences.
// tc flags the last step (count == all ones); the counter then wraps to zero.
module muldiv_step_cnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Step counter with synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply/divide: one bit per cycle, fixed latency,
// registered result with a single-cycle ready pulse.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  output logic              ready,
  output logic [2*DATA_W-1:0] out
);

  muldiv_state_e state_q, state_d;

  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] out_q, out_d;
  logic                ready_q, ready_d;

  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt;

  // Multiply step: add multiplicand into the upper half, then shift right with carry.
  logic [DATA_W-1:0]   mul_addend;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;

  assign mul_addend = op_b_q[0] ? op_a_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide step: shift {rem,quo} left, trial-subtract divisor from the widened remainder.
  logic [2*DATA_W:0]   div_sh;
  logic [DATA_W:0]     div_trial;
  logic [2*DATA_W-1:0] div_next;

  assign div_sh    = {acc_q, 1'b0};
  assign div_trial = div_sh[2*DATA_W:DATA_W] - {1'b0, op_b_q};
  assign div_next  = div_trial[DATA_W] ? {div_sh[2*DATA_W-1:DATA_W], div_sh[DATA_W-1:1], 1'b0}
                                       : {div_trial[DATA_W-1:0], div_sh[DATA_W-1:1], 1'b1};

  muldiv_step_cnt #(
    .CNT_W(CNT_W)
  ) u_step_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  // Next-state, datapath and result update.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ready_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          op_a_d  = in_A;
          op_b_d  = in_B;
          cnt_clr = 1'b1;
          // Divide keeps the dividend in the quotient half and shifts it into rem.
          acc_d   = (mode == MODE_DIV) ? {{DATA_W{1'b0}}, in_A} : '0;
          state_d = (mode == MODE_DIV) ? StDiv : StMul;
        end
      end
      StMul: begin
        acc_d  = mul_next;
        op_b_d = op_b_q >> 1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StDone;
          ready_d = 1'b1;
          out_d   = mul_next;
        end
      end
      StDiv: begin
        acc_d  = div_next;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StDone;
          ready_d = 1'b1;
          out_d   = div_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign out   = out_q;

endmodule

// File: tb/tb_muldiv_core.sv
// Self-checking bench for muldiv_core: directed corner cases plus random
// operations checked against plain-arithmetic reference results.
module tb_muldiv_core;
  import muldiv_pkg::*;

  localparam int W = 32;
  // Edges after the capture edge until ready is first seen (E1..E32).
  localparam int LatEdges = 32;

  logic           clk;
  logic           rst_n;
  logic           valid;
  logic           mode;
  logic [W-1:0]   in_A;
  logic [W-1:0]   in_B;
  logic           ready;
  logic [2*W-1:0] out;

  int n_vec = 0;
  int n_err = 0;

  muldiv_core #(
    .DATA_W(W),
    .CNT_W (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(valid),
    .mode (mode),
    .in_A (in_A),
    .in_B (in_B),
    .ready(ready),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_result(input logic m, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint unsigned aa, bb;
    aa = a;
    bb = b;
    if (m == MODE_MUL) return aa * bb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {W'(aa % bb), W'(aa / bb)};
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present an operation for one capture edge, then scramble the inputs.
  task automatic start_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    valid = 1'b1;
    mode  = m;
    in_A  = a;
    in_B  = b;
    @(posedge clk);
    #1;
    valid = 1'b0;
    mode  = 1'($urandom);
    in_A  = $urandom;
    in_B  = $urandom;
  endtask

  task automatic wait_ready(output int edges);
    int n;
    n = 0;
    edges = -1;
    while (n < 100 && edges < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) edges = n;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
  endtask

  task automatic run_check(input string tag, input logic m, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    int             lat;
    logic [2*W-1:0] exp;
    exp = ref_result(m, a, b);
    start_op(m, a, b);
    wait_ready(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LatEdges));
    check({tag, "_out"}, out, exp);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(ready), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_hold"}, out, exp);
  endtask

  initial begin
    int             lat, pulses, p1, p2, n;
    logic           m;
    logic [W-1:0]   a, b;

    rst_n = 1'b0;
    valid = 1'b0;
    mode  = MODE_MUL;
    in_A  = '0;
    in_B  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_out", out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("mul_7x6", MODE_MUL, 32'd7, 32'd6);
    run_check("mul_max", MODE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_max_const", out, 64'hFFFF_FFFE_0000_0001);
    run_check("div_100_7", MODE_DIV, 32'd100, 32'd7);
    check("div_100_7_const", out, {32'd2, 32'd14});
    run_check("div_5_9", MODE_DIV, 32'd5, 32'd9);
    run_check("div_by0", MODE_DIV, 32'h1234_5678, 32'd0);
    check("div_by0_const", out, {32'h1234_5678, 32'hFFFF_FFFF});

    // valid pulsed mid-operation must be ignored
    start_op(MODE_MUL, 32'd3, 32'd4);
    n = 0;
    lat = -1;
    while (n < 100 && lat < 0) begin
      @(posedge clk);
      #1;
      n++;
      valid = (n == 9);
      if (n == 9) begin
        mode = MODE_DIV;
        in_A = 32'd9;
        in_B = 32'd3;
      end
      if (ready) lat = n;
    end
    valid = 1'b0;
    check("ign_lat", 64'(lat), 64'(LatEdges));
    check("ign_out", out, 64'd12);
    count_pulses(40, pulses);
    check("ign_pulses", 64'(pulses), 64'd0);

    // valid held high: back-to-back operations every 34 cycles
    @(negedge clk);
    valid = 1'b1;
    mode  = MODE_MUL;
    in_A  = 32'd1000;
    in_B  = 32'd77;
    @(posedge clk);
    #1;
    n = 0;
    p1 = -1;
    p2 = -1;
    while (n < 200 && p2 < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) begin
        if (p1 < 0) p1 = n;
        else p2 = n;
      end
    end
    valid = 1'b0;
    check("b2b_first", 64'(p1), 64'(LatEdges));
    check("b2b_period", 64'(p2 - p1), 64'd34);
    check("b2b_out", out, 64'd77000);
    count_pulses(40, pulses);
    check("b2b_drain", 64'(pulses), 64'd0);

    // reset mid-divide aborts with no ready pulse
    start_op(MODE_DIV, 32'd123456, 32'd789);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_out", out, 64'd0);
    rst_n = 1'b1;
    count_pulses(40, pulses);
    check("abort_pulses", 64'(pulses), 64'd0);
    run_check("mul_2x3", MODE_MUL, 32'd2, 32'd3);

    // random operations, including small divisors and zero divisors
    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      run_check($sformatf("rand%0d", i), m, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
